// File: rtl/timeout_scheduler_pkg.sv
// Shared widths, backoff limits and FSM encodings for the timeout scheduler.
// The backoff helper is only referenced when TIMEOUT_BACKOFF_EN is defined.
package timeout_scheduler_pkg;

    localparam int unsigned TIME_W     = 16;
    localparam int unsigned TIMER_W    = 12;
    localparam int unsigned BEXP_W     = 3;
    localparam int unsigned BEXP_MAX_I = 7;
    localparam logic [BEXP_W-1:0] BEXP_MAX = 3'd7;

    typedef enum logic {
        TOS_SCAN  = 1'b0,
        TOS_ISSUE = 1'b1
    } tos_state_e;

    // amnt << bexp, saturating to all-ones when any bit would be shifted out
    function automatic logic [TIMER_W-1:0] backoff_amnt(input logic [TIMER_W-1:0] amnt,
                                                        input logic [BEXP_W-1:0]  bexp);
        logic [TIMER_W+BEXP_MAX_I-1:0] wide;
        wide = {{BEXP_MAX_I{1'b0}}, amnt} << bexp;
        if (|wide[TIMER_W+BEXP_MAX_I-1:TIMER_W]) begin
            return '1;
        end
        return wide[TIMER_W-1:0];
    endfunction

endpackage

// File: rtl/timeout_expiry_cmp.sv
// Wrap-aware deadline compare: expired when now is at or past deadline
// within half the time range.
module timeout_expiry_cmp
    import timeout_scheduler_pkg::*;
(
    input  logic [TIME_W-1:0] now,
    input  logic [TIME_W-1:0] deadline,
    output logic              expired
);

    logic [TIME_W-1:0] diff;

    always_comb begin
        diff    = now - deadline;
        expired = ~diff[TIME_W-1];
    end

endmodule

// File: rtl/timeout_scheduler.sv
// Per-flow retransmission timer table with a round-robin expiry scanner and a
// single-entry valid/ready event output. Optional macro: TIMEOUT_BACKOFF_EN.
module timeout_scheduler
    import timeout_scheduler_pkg::*;
#(
    parameter int unsigned FLOW_CNT  = 16,
    parameter int unsigned FLOW_ID_W = $clog2(FLOW_CNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TIME_W-1:0]    now,
    input  logic                 arm_valid,
    input  logic [FLOW_ID_W-1:0] arm_flow_id,
    input  logic [TIMER_W-1:0]   arm_amnt,
    input  logic                 disarm_valid,
    input  logic [FLOW_ID_W-1:0] disarm_flow_id,
    input  logic                 scan_en,
    output logic                 to_valid,
    input  logic                 to_ready,
    output logic [FLOW_ID_W-1:0] to_flow_id,
`ifdef TIMEOUT_BACKOFF_EN
    input  logic                 arm_clr_backoff,
    output logic [BEXP_W-1:0]    to_backoff,
`endif
    output logic [FLOW_ID_W:0]   armed_cnt
);

    tos_state_e           state_q, state_d;
    logic [FLOW_CNT-1:0]  armed_q, armed_d;
    logic [TIME_W-1:0]    deadline_q [FLOW_CNT];
    logic [TIME_W-1:0]    deadline_d;
    logic [FLOW_ID_W-1:0] ptr_q, ptr_d;
    logic [FLOW_ID_W-1:0] to_flow_id_q, to_flow_id_d;
    logic [FLOW_ID_W:0]   armed_cnt_q, armed_cnt_d;
    logic [TIMER_W-1:0]   eff_amnt;
    logic                 expired;
    logic                 arm_hit_ptr;
    logic                 disarm_hit_ptr;
`ifdef TIMEOUT_BACKOFF_EN
    logic [BEXP_W-1:0]    bexp_q [FLOW_CNT];
    logic [BEXP_W-1:0]    bexp_d [FLOW_CNT];
    logic [BEXP_W-1:0]    to_backoff_q, to_backoff_d;
`endif

    timeout_expiry_cmp u_expiry_cmp (
        .now      (now),
        .deadline (deadline_q[ptr_q]),
        .expired  (expired)
    );

    always_comb begin
        state_d        = state_q;
        armed_d        = armed_q;
        ptr_d          = ptr_q;
        to_flow_id_d   = to_flow_id_q;
        arm_hit_ptr    = arm_valid && (arm_flow_id == ptr_q);
        disarm_hit_ptr = disarm_valid && (disarm_flow_id == ptr_q);
`ifdef TIMEOUT_BACKOFF_EN
        bexp_d         = bexp_q;
        to_backoff_d   = to_backoff_q;
        eff_amnt       = backoff_amnt(arm_amnt, arm_clr_backoff ? '0 : bexp_q[arm_flow_id]);
`else
        eff_amnt       = arm_amnt;
`endif
        deadline_d     = now + TIME_W'(eff_amnt);

        case (state_q)
            TOS_SCAN: begin
                if (scan_en) begin
                    ptr_d = ptr_q + 1'b1;
                    // a same-cycle arm/disarm of the scanned flow overrides its expiry
                    if (armed_q[ptr_q] && expired && !arm_hit_ptr && !disarm_hit_ptr) begin
                        armed_d[ptr_q] = 1'b0;
                        to_flow_id_d   = ptr_q;
                        state_d        = TOS_ISSUE;
`ifdef TIMEOUT_BACKOFF_EN
                        to_backoff_d   = bexp_q[ptr_q];
                        if (bexp_q[ptr_q] != BEXP_MAX) begin
                            bexp_d[ptr_q] = bexp_q[ptr_q] + 1'b1;
                        end
`endif
                    end
                end
            end
            TOS_ISSUE: begin
                if (to_ready) begin
                    state_d = TOS_SCAN;
                end
            end
            default: state_d = TOS_SCAN;
        endcase

        if (disarm_valid) begin
            armed_d[disarm_flow_id] = 1'b0;
        end
        if (arm_valid) begin
            armed_d[arm_flow_id] = 1'b1;
`ifdef TIMEOUT_BACKOFF_EN
            if (arm_clr_backoff) begin
                bexp_d[arm_flow_id] = '0;
            end
`endif
        end

        armed_cnt_d = '0;
        for (int unsigned i = 0; i < FLOW_CNT; i++) begin
            armed_cnt_d = armed_cnt_d + (FLOW_ID_W+1)'(armed_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= TOS_SCAN;
            armed_q      <= '0;
            ptr_q        <= '0;
            to_flow_id_q <= '0;
            armed_cnt_q  <= '0;
`ifdef TIMEOUT_BACKOFF_EN
            to_backoff_q <= '0;
            for (int unsigned i = 0; i < FLOW_CNT; i++) begin
                bexp_q[i] <= '0;
            end
`endif
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            ptr_q        <= ptr_d;
            to_flow_id_q <= to_flow_id_d;
            armed_cnt_q  <= armed_cnt_d;
`ifdef TIMEOUT_BACKOFF_EN
            to_backoff_q <= to_backoff_d;
            bexp_q       <= bexp_d;
`endif
        end
    end

    // deadlines are only meaningful while armed, so they carry no reset
    always_ff @(posedge clk) begin
        if (arm_valid) begin
            deadline_q[arm_flow_id] <= deadline_d;
        end
    end

    assign to_valid   = (state_q == TOS_ISSUE);
    assign to_flow_id = to_flow_id_q;
    assign armed_cnt  = armed_cnt_q;
`ifdef TIMEOUT_BACKOFF_EN
    assign to_backoff = to_backoff_q;
`endif

endmodule
